prog_loader: RTL and testbench

//   Upstream program loader for the CU/bus/memory-bank stage. Accepts a valid/ready

---
 rtl/prog_loader_if.sv | 30 +++
 rtl/prog_loader.sv | 156 +++++++++++++++
 tb/tb_prog_loader.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Stream and bank-side signal bundle for the program loader.
// The master modport is the stream/bank side; the slave modport is the loader itself.
interface prog_loader_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   logic              start;
   logic [ADDR_W:0]   load_len;
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] user_address;
   logic [DATA_W-1:0] data_out;
   logic              write_memory;
   logic              op;
   logic              busy;
   logic              done;
   logic              err;
   logic [DATA_W-1:0] checksum;

   modport master (
      output start, load_len, in_data, in_valid,
      input  in_ready, user_address, data_out, write_memory, op, busy, done, err, checksum
   );

   modport slave (
      input  start, load_len, in_data, in_valid,
      output in_ready, user_address, data_out, write_memory, op, busy, done, err, checksum
   );
endinterface

// File: rtl/prog_loader.sv
// Program loader: copies a valid/ready byte stream into the 16x8 bank through its user
// port, one write pulse per byte, then hands the bank to the control unit (op=1).
//
// state  | meaning
// IDLE   | after reset, waiting for a legal start
// ACCEPT | in_ready high, waiting for the next stream byte
// WRITE  | write_memory pulse cycle
// GAP    | write_memory low for GAP_CYCLES before next byte or completion
// RUN    | load complete, op held high, a new start may reload
module prog_loader #(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 4,
   parameter int GAP_CYCLES = 1
) (
   input  logic         clk,
   input  logic         reset,
   prog_loader_if.slave bus
);
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
   localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W+1)'(2**ADDR_W);
   localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);

   typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_WRITE, S_GAP, S_RUN} state_t;

   state_t              state, state_nxt;
   logic [ADDR_W:0]     len_q, len_d;
   logic [GAP_W-1:0]    gap_cnt, gap_cnt_d;
   logic                in_ready_q, in_ready_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                wr_q, wr_d;
   logic                op_q, op_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   sum_q, sum_d;

   logic len_legal, last_byte, gap_tc, handshake;

   assign len_legal = (bus.load_len != '0) && (bus.load_len <= DEPTH_V);
   assign last_byte = ({1'b0, addr_q} == (len_q - LEN_ONE));
   assign gap_tc    = (gap_cnt == '0);
   assign handshake = bus.in_valid & in_ready_q;

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_RUN: if (bus.start && len_legal) state_nxt = S_ACCEPT;
         S_ACCEPT:      if (handshake) state_nxt = S_WRITE;
         S_WRITE:       state_nxt = S_GAP;
         S_GAP:         if (gap_tc) state_nxt = last_byte ? S_RUN : S_ACCEPT;
         default:       state_nxt = S_IDLE;
      endcase
   end

   // Next values of the registered outputs; everything holds unless the state says otherwise.
   always_comb begin
      len_d      = len_q;
      gap_cnt_d  = gap_cnt;
      in_ready_d = in_ready_q;
      addr_d     = addr_q;
      data_d     = data_q;
      wr_d       = wr_q;
      op_d       = op_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = err_q;
      sum_d      = sum_q;
      case (state)
         S_IDLE, S_RUN: begin
            if (bus.start) begin
               if (len_legal) begin
                  len_d      = bus.load_len;
                  err_d      = 1'b0;
                  sum_d      = '0;
                  addr_d     = '0;
                  busy_d     = 1'b1;
                  op_d       = 1'b0;
                  in_ready_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_ACCEPT: begin
            if (handshake) begin
               data_d     = bus.in_data;
               sum_d      = sum_q + bus.in_data;
               in_ready_d = 1'b0;
               wr_d       = 1'b1;
            end
         end
         S_WRITE: begin
            wr_d      = 1'b0;
            gap_cnt_d = GAP_LOAD;
         end
         S_GAP: begin
            if (!gap_tc) begin
               gap_cnt_d = gap_cnt - GAP_W'(1);
            end else if (last_byte) begin
               op_d   = 1'b1;
               busy_d = 1'b0;
               done_d = 1'b1;
            end else begin
               addr_d     = addr_q + ADDR_W'(1);
               in_ready_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         len_q      <= '0;
         gap_cnt    <= '0;
         in_ready_q <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         wr_q       <= 1'b0;
         op_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         sum_q      <= '0;
      end else begin
         len_q      <= len_d;
         gap_cnt    <= gap_cnt_d;
         in_ready_q <= in_ready_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         wr_q       <= wr_d;
         op_q       <= op_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         sum_q      <= sum_d;
      end
   end

   assign bus.in_ready     = in_ready_q;
   assign bus.user_address = addr_q;
   assign bus.data_out     = data_q;
   assign bus.write_memory = wr_q;
   assign bus.op           = op_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.err          = err_q;
   assign bus.checksum     = sum_q;
endmodule

// File: tb/tb_prog_loader.sv
// Randomized scoreboard bench for prog_loader: the driver pushes expected bank writes and
// completion checksums; a negedge monitor pops them whenever the loader writes or finishes.
module tb_prog_loader;
   typedef struct packed {
      logic [3:0] a;
      logic [7:0] d;
   } wr_t;
   typedef logic [7:0] byte_q_t[$];

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;
   bit   exp_op = 1'b0;

   wr_t        exp_wr[$];
   logic [7:0] exp_done[$];
   logic [7:0] mem[16];
   bit         wr_prev = 1'b0;

   prog_loader_if #(.DATA_W(8), .ADDR_W(4)) bus ();

   prog_loader #(.DATA_W(8), .ADDR_W(4), .GAP_CYCLES(1)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Bank-side monitor and scoreboard
   always @(negedge clk) begin
      if (bus.write_memory === 1'b1) begin
         chk("wr_pulse_width", {31'd0, wr_prev}, 32'd0);
         if (exp_wr.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: addr %0h data %0h, none expected", bus.user_address, bus.data_out);
         end else begin
            wr_t e;
            e = exp_wr.pop_front();
            chk("wr_addr", {28'd0, bus.user_address}, {28'd0, e.a});
            chk("wr_data", {24'd0, bus.data_out}, {24'd0, e.d});
         end
         mem[bus.user_address] = bus.data_out;
      end
      if (bus.done === 1'b1) begin
         if (exp_done.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: checksum %0h, none expected", bus.checksum);
         end else begin
            logic [7:0] s;
            s = exp_done.pop_front();
            chk("done_checksum", {24'd0, bus.checksum}, {24'd0, s});
            chk("done_op", {31'd0, bus.op}, 32'd1);
            chk("done_busy", {31'd0, bus.busy}, 32'd0);
         end
      end
      wr_prev = (bus.write_memory === 1'b1);
   end

   task automatic reset_dut();
      bus.start = 1'b0; bus.load_len = '0; bus.in_data = '0; bus.in_valid = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_op = 1'b0;
   endtask

   task automatic do_start(input int len);
      bus.start = 1'b1;
      bus.load_len = 5'(len);
      @(negedge clk);
      bus.start = 1'b0;
      bus.load_len = 5'($urandom);
   endtask

   task automatic illegal_start(input int len);
      do_start(len);
      chk("illegal_err", {31'd0, bus.err}, 32'd1);
      chk("illegal_busy", {31'd0, bus.busy}, 32'd0);
      chk("illegal_op", {31'd0, bus.op}, {31'd0, exp_op});
      repeat (3) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic [3:0] a, input int bubble, input bit chk_gap);
      int w;
      exp_wr.push_back('{a: a, d: b});
      bus.in_valid = 1'b0;
      for (int k = 0; k < bubble; k++) begin
         bus.start = ($urandom_range(0, 3) == 0);
         bus.load_len = 5'($urandom_range(1, 16));
         bus.in_data = 8'($urandom);
         @(negedge clk);
      end
      bus.start = 1'b0;
      if (bubble >= 3) chk("bubble_in_ready", {31'd0, bus.in_ready}, 32'd1);
      bus.in_data = b;
      bus.in_valid = 1'b1;
      w = 0;
      while (bus.in_ready !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (w >= 20) chk("accept_timeout", 32'(w), 32'd0);
      else if (chk_gap) chk("accept_spacing", 32'(w), 32'd2);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data = 8'($urandom);
   endtask

   task automatic do_load(input byte_q_t bytes, input int max_bub, input int fix_idx, input int fix_len, input bit chk_gap);
      int len;
      int w;
      int bub;
      logic [7:0] sum;
      len = bytes.size();
      sum = 8'(0);
      foreach (bytes[i]) sum = sum + bytes[i];
      do_start(len);
      chk("start_busy", {31'd0, bus.busy}, 32'd1);
      chk("start_op", {31'd0, bus.op}, 32'd0);
      chk("start_err", {31'd0, bus.err}, 32'd0);
      for (int i = 0; i < len; i++) begin
         bub = (max_bub > 0) ? $urandom_range(0, max_bub) : 0;
         if (i == fix_idx) bub = fix_len;
         if (i == len - 1) exp_done.push_back(sum);
         send_byte(bytes[i], 4'(i), bub, chk_gap && (i > 0) && (bub == 0));
      end
      w = 0;
      while (bus.busy !== 1'b0 && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (w >= 20) chk("done_timeout", 32'(w), 32'd0);
      @(negedge clk);
      exp_op = 1'b1;
      chk("end_op", {31'd0, bus.op}, 32'd1);
      chk("end_busy", {31'd0, bus.busy}, 32'd0);
      chk("end_checksum", {24'd0, bus.checksum}, {24'd0, sum});
      chk("end_err", {31'd0, bus.err}, 32'd0);
      chk("end_writes_left", 32'(exp_wr.size()), 32'd0);
      chk("end_done_left", 32'(exp_done.size()), 32'd0);
      for (int i = 0; i < len; i++) chk("bank_word", {24'd0, mem[i]}, {24'd0, bytes[i]});
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      byte_q_t bq;
      reset_dut();
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("rst_addr", {28'd0, bus.user_address}, 32'd0);
      chk("rst_data", {24'd0, bus.data_out}, 32'd0);
      chk("rst_wr", {31'd0, bus.write_memory}, 32'd0);
      chk("rst_op", {31'd0, bus.op}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_err", {31'd0, bus.err}, 32'd0);
      chk("rst_checksum", {24'd0, bus.checksum}, 32'd0);

      // Three bytes back to back, then with a bubble before the third
      bq = '{8'h03, 8'h07, 8'h0B};
      do_load(bq, 0, -1, 0, 1'b1);
      do_load(bq, 0, 2, 4, 1'b1);

      // Reload from RUN with a single byte
      bq = '{8'hAA};
      do_load(bq, 0, -1, 0, 1'b1);

      // Full depth, no address wrap
      bq = {};
      for (int i = 0; i < 16; i++) bq.push_back(8'hF0 + 8'(i));
      do_load(bq, 0, -1, 0, 1'b1);
      chk("full_checksum", {24'd0, bus.checksum}, 32'h78);
      chk("full_last_addr", {28'd0, bus.user_address}, 32'hF);

      // Illegal start in RUN keeps op high
      illegal_start(0);

      // Reset in the middle of a load
      do_start(3);
      send_byte(8'h11, 4'd0, 0, 1'b0);
      send_byte(8'h22, 4'd1, 0, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_op = 1'b0;
      chk("midrst_op", {31'd0, bus.op}, 32'd0);
      chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
      chk("midrst_wr", {31'd0, bus.write_memory}, 32'd0);
      chk("midrst_addr", {28'd0, bus.user_address}, 32'd0);
      chk("midrst_checksum", {24'd0, bus.checksum}, 32'd0);
      chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("midrst_writes_left", 32'(exp_wr.size()), 32'd0);

      // Illegal lengths from IDLE
      illegal_start(0);
      illegal_start(17);

      // Randomized loads interleaved with illegal starts
      for (int n = 0; n < 25; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            illegal_start(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(17, 31)));
         end else begin
            bq = {};
            for (int i = 0; i < int'($urandom_range(1, 16)); i++) bq.push_back(8'($urandom));
            do_load(bq, 3, -1, 0, 1'b0);
         end
      end

      repeat (5) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
